soc_system_onchip_ram_pipelined: RTL and testbench

//  Parametrised on-chip RAM with an Avalon-MM slave; next generation of the fixed 256x4000 single-port block.

---
 rtl/soc_system_onchip_ram_pipelined.sv | 90 +++++++++
 tb/tb_soc_system_onchip_ram_pipelined.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_system_onchip_ram_pipelined.sv
// rtl/soc_system_onchip_ram_pipelined.sv - Avalon-MM on-chip RAM with pipelined reads and clear engine
module soc_system_onchip_ram_pipelined #(
  parameter int DATA_WIDTH     = 256,
  parameter int ADDR_WIDTH     = 12,
  parameter int DEPTH          = 4000,
  parameter int READ_LATENCY   = 1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic                    chipselect,
  input  logic                    read,
  input  logic                    write,
  input  logic [DATA_WIDTH-1:0]   writedata,
  input  logic                    clken,
  input  logic                    freeze,
  input  logic                    reset_req,
  output logic                    waitrequest,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    readdatavalid,
  output logic                    busy_clearing
);
  localparam int NB = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ctr_q;
  logic                    en, clearing, accept, rd_acc, wr_acc, in_range;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [READ_LATENCY-1:0] vld_q;
  logic [DATA_WIDTH-1:0]   dat_q [READ_LATENCY];

  assign en            = clken & ~reset_req;
  assign clearing      = (state_q == CLEAR);
  // Reset term keeps the slave stalled while reset_n is low even when no clear is configured.
  assign waitrequest   = ~reset_n | clearing | ~en;
  assign accept        = chipselect & ~waitrequest & (read | write);
  assign wr_acc        = accept & write;
  assign rd_acc        = accept & read & ~write;
  assign in_range      = {1'b0, address} < DEPTH_W;
  assign busy_clearing = clearing;
  assign readdatavalid = vld_q[READ_LATENCY-1];
  assign readdata      = dat_q[READ_LATENCY-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= CLEAR_ON_RESET ? CLEAR : READY;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clearing && en && ctr_q == LAST) state_d = READY;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                               ctr_q <= '0;
    else if (clearing && en && ctr_q != LAST)   ctr_q <= ctr_q + 1'b1;
  end

  // Bus writes only happen in READY, so they never collide with clear writes.
  always_ff @(posedge clk) begin
    if (en && clearing) begin
      mem[ctr_q] <= '0;
    end else if (wr_acc && !freeze && in_range) begin
      for (int b = 0; b < NB; b++) begin
        if (byteenable[b]) mem[address][8*b +: 8] <= writedata[8*b +: 8];
      end
    end
  end

  // Stage data only advances alongside a valid so readdata holds between strobes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) dat_q[i] <= '0;
    end else if (en) begin
      vld_q[0] <= rd_acc;
      if (rd_acc) dat_q[0] <= in_range ? mem[address] : '0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
      end
    end
  end
endmodule

// File: tb/tb_soc_system_onchip_ram_pipelined.sv
// tb/tb_soc_system_onchip_ram_pipelined.sv - self-checking bench for soc_system_onchip_ram_pipelined
module tb_soc_system_onchip_ram_pipelined;
  localparam int DW = 32, AW = 5, DEPTH = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, chipselect, read, write, clken, freeze, reset_req;
  logic [AW-1:0] address; logic [3:0] byteenable; logic [DW-1:0] writedata;
  logic waitrequest, readdatavalid, busy_clearing; logic [DW-1:0] readdata;

  logic b_reset_n, b_chipselect, b_read, b_write, b_clken, b_freeze, b_reset_req;
  logic [AW-1:0] b_address; logic [3:0] b_byteenable; logic [DW-1:0] b_writedata;
  logic b_waitrequest, b_readdatavalid, b_busy_clearing; logic [DW-1:0] b_readdata;

  int total = 0, bad = 0;
  logic [DW-1:0] ref_mem [DEPTH];

  soc_system_onchip_ram_pipelined #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
    .READ_LATENCY(1), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
    .clken(clken), .freeze(freeze), .reset_req(reset_req), .waitrequest(waitrequest),
    .readdata(readdata), .readdatavalid(readdatavalid), .busy_clearing(busy_clearing));

  soc_system_onchip_ram_pipelined #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
    .READ_LATENCY(2), .CLEAR_ON_RESET(1'b0)) dut_b (
    .clk(clk), .reset_n(b_reset_n), .address(b_address), .byteenable(b_byteenable),
    .chipselect(b_chipselect), .read(b_read), .write(b_write), .writedata(b_writedata),
    .clken(b_clken), .freeze(b_freeze), .reset_req(b_reset_req), .waitrequest(b_waitrequest),
    .readdata(b_readdata), .readdatavalid(b_readdatavalid), .busy_clearing(b_busy_clearing));

  function automatic logic [DW-1:0] ref_read(input int a);
    return (a < DEPTH) ? ref_mem[a] : '0;
  endfunction

  function automatic void ref_write(input int a, input logic [DW-1:0] d, input logic [3:0] be,
                                    input logic frz);
    if (frz || a >= DEPTH) return;
    for (int b = 0; b < 4; b++) if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
  endfunction

  function automatic void ref_clear();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endfunction

  // Drivers are entered at a negedge and return at a negedge.
  task automatic a_write(input int a, input logic [DW-1:0] d, input logic [3:0] be, output logic acc);
    address = a[AW-1:0]; writedata = d; byteenable = be;
    chipselect = 1; write = 1; read = 0;
    #1 acc = !waitrequest;
    @(negedge clk);
    chipselect = 0; write = 0;
    if (acc) ref_write(a, d, be, freeze);
  endtask

  task automatic a_read(input int a, output logic [DW-1:0] d, output int lat, output logic acc);
    address = a[AW-1:0]; chipselect = 1; read = 1; write = 0;
    #1 acc = !waitrequest;
    @(negedge clk);
    chipselect = 0; read = 0;
    lat = 1;
    while (!readdatavalid && lat < 8) begin @(negedge clk); lat++; end
    d = readdata;
  endtask

  task automatic b_do_write(input int a, input logic [DW-1:0] d, input logic [3:0] be);
    b_address = a[AW-1:0]; b_writedata = d; b_byteenable = be;
    b_chipselect = 1; b_write = 1; b_read = 0;
    @(negedge clk);
    b_chipselect = 0; b_write = 0;
  endtask

  task automatic b_do_read(input int a, output logic [DW-1:0] d, output int lat);
    b_address = a[AW-1:0]; b_chipselect = 1; b_read = 1; b_write = 0;
    @(negedge clk);
    b_chipselect = 0; b_read = 0;
    lat = 1;
    while (!b_readdatavalid && lat < 8) begin @(negedge clk); lat++; end
    d = b_readdata;
  endtask

  task automatic test_reset();
    logic [DW-1:0] d; int lat, n, wn; logic acc;
    chipselect = 0; read = 0; write = 0; clken = 1; reset_req = 0; freeze = 0;
    address = '0; byteenable = '0; writedata = '0;
    reset_n = 0;
    repeat (3) @(negedge clk);
    total++; if (waitrequest !== 1'b1) begin bad++; $display("FAIL reset_waitrequest got=%b exp=1", waitrequest); end
    total++; if (busy_clearing !== 1'b1) begin bad++; $display("FAIL reset_busy got=%b exp=1", busy_clearing); end
    total++; if (readdatavalid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", readdatavalid); end
    total++; if (readdata !== '0) begin bad++; $display("FAIL reset_readdata got=%h exp=0", readdata); end
    reset_n = 1;
    n = 0; wn = 0;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (!busy_clearing) break;
      n++;
      if (waitrequest) wn++;
      @(negedge clk);
    end
    ref_clear();
    total++; if (n !== DEPTH) begin bad++; $display("FAIL clear_cycles got=%0d exp=%0d", n, DEPTH); end
    total++; if (wn !== DEPTH) begin bad++; $display("FAIL clear_wait_cycles got=%0d exp=%0d", wn, DEPTH); end
    total++; if (waitrequest !== 1'b0) begin bad++; $display("FAIL ready_waitrequest got=%b exp=0", waitrequest); end
    for (int a = 0; a < DEPTH; a++) begin
      a_read(a, d, lat, acc);
      total++; if (acc !== 1'b1) begin bad++; $display("FAIL cleared_accept addr=%0d got=%b exp=1", a, acc); end
      total++; if (lat !== 1) begin bad++; $display("FAIL cleared_latency addr=%0d got=%0d exp=1", a, lat); end
      total++; if (d !== ref_read(a)) begin bad++; $display("FAIL cleared_data addr=%0d got=%h exp=%h", a, d, ref_read(a)); end
    end
  endtask

  task automatic test_byte_write();
    logic [DW-1:0] d, wd; int lat, a, ra; logic acc; logic [3:0] be;
    a_write(3, 32'hDEADBEEF, 4'b0101, acc);
    total++; if (acc !== 1'b1) begin bad++; $display("FAIL bw_accept got=%b exp=1", acc); end
    a_read(3, d, lat, acc);
    total++; if (lat !== 1) begin bad++; $display("FAIL bw_latency got=%0d exp=1", lat); end
    total++; if (d !== ref_read(3)) begin bad++; $display("FAIL bw_data got=%h exp=%h", d, ref_read(3)); end
    for (int k = 0; k < 12; k++) begin
      a = $urandom_range(0, 31);
      if (a == 5) a = 6;
      wd = $urandom; be = 4'($urandom_range(0, 15));
      a_write(a, wd, be, acc);
      ra = ($urandom_range(0, 1) == 1) ? a : $urandom_range(0, 31);
      a_read(ra, d, lat, acc);
      total++; if (d !== ref_read(ra) || lat !== 1)
        begin bad++; $display("FAIL rand_rw addr=%0d got=%h lat=%0d exp=%h lat=1", ra, d, lat, ref_read(ra)); end
    end
  endtask

  task automatic test_read_write_collision();
    logic [DW-1:0] d, wd; int lat, nv; logic acc;
    wd = $urandom;
    address = 5'd7; writedata = wd; byteenable = 4'hF; chipselect = 1; read = 1; write = 1;
    #1 acc = !waitrequest;
    @(negedge clk);
    chipselect = 0; read = 0; write = 0;
    if (acc) ref_write(7, wd, 4'hF, freeze);
    nv = 0;
    for (int c = 0; c < 3; c++) begin #1; if (readdatavalid) nv++; @(negedge clk); end
    total++; if (nv !== 0) begin bad++; $display("FAIL collision_valids got=%0d exp=0", nv); end
    a_read(7, d, lat, acc);
    total++; if (d !== ref_read(7)) begin bad++; $display("FAIL collision_data got=%h exp=%h", d, ref_read(7)); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] got[$]; logic acc;
    for (int a = 0; a < 3; a++) a_write(a, $urandom, 4'hF, acc);
    @(negedge clk);
    for (int s = 0; s < 7; s++) begin
      chipselect = (s < 4); read = (s < 4); write = 0;
      address = (s == 0) ? 5'd0 : (s == 1) ? 5'd1 : 5'd2;
      clken = (s != 2);
      #1;
      if (s == 2) begin
        total++; if (waitrequest !== 1'b1) begin bad++; $display("FAIL stall_waitrequest got=%b exp=1", waitrequest); end
      end
      if (readdatavalid && clken) got.push_back(readdata);
      @(negedge clk);
    end
    chipselect = 0; read = 0; clken = 1;
    total++; if (got.size() !== 3) begin bad++; $display("FAIL b2b_count got=%0d exp=3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      total++; if (got[i] !== ref_read(i)) begin bad++; $display("FAIL b2b_data idx=%0d got=%h exp=%h", i, got[i], ref_read(i)); end
    end
  endtask

  task automatic test_freeze();
    logic [DW-1:0] d; int lat; logic acc;
    freeze = 1;
    a_write(5, 32'h12345678, 4'hF, acc);
    freeze = 0;
    total++; if (acc !== 1'b1) begin bad++; $display("FAIL freeze_accept got=%b exp=1", acc); end
    a_read(5, d, lat, acc);
    total++; if (d !== ref_read(5)) begin bad++; $display("FAIL freeze_data got=%h exp=%h", d, ref_read(5)); end
    a_write(25, 32'hCAFEF00D, 4'hF, acc);
    total++; if (acc !== 1'b1) begin bad++; $display("FAIL oor_accept got=%b exp=1", acc); end
    a_read(25, d, lat, acc);
    total++; if (d !== ref_read(25) || lat !== 1) begin bad++; $display("FAIL oor_data got=%h lat=%0d exp=%h lat=1", d, lat, ref_read(25)); end
  endtask

  task automatic test_reset_during_clear();
    logic [DW-1:0] d; int lat, en_cnt, nw; logic acc;
    a_read(3, d, lat, acc);
    reset_n = 0;
    #1;
    total++; if (readdatavalid !== 1'b0) begin bad++; $display("FAIL async_valid got=%b exp=0", readdatavalid); end
    total++; if (readdata !== '0) begin bad++; $display("FAIL async_readdata got=%h exp=0", readdata); end
    @(negedge clk);
    reset_n = 1;
    repeat (10) @(negedge clk);
    total++; if (busy_clearing !== 1'b1) begin bad++; $display("FAIL midclear_busy got=%b exp=1", busy_clearing); end
    reset_n = 0;
    #1;
    total++; if (readdatavalid !== 1'b0 || waitrequest !== 1'b1)
      begin bad++; $display("FAIL midclear_reset valid=%b wait=%b exp valid=0 wait=1", readdatavalid, waitrequest); end
    @(negedge clk);
    reset_n = 1;
    en_cnt = 0; nw = 0;
    for (int c = 0; c < 200; c++) begin
      clken = ($urandom_range(0, 3) != 0);
      reset_req = ($urandom_range(0, 4) == 0);
      #1;
      if (!busy_clearing) break;
      if (clken && !reset_req) en_cnt++;
      if (!waitrequest) nw++;
      @(negedge clk);
    end
    clken = 1; reset_req = 0;
    ref_clear();
    total++; if (en_cnt !== DEPTH) begin bad++; $display("FAIL restart_enabled_cycles got=%0d exp=%0d", en_cnt, DEPTH); end
    total++; if (nw !== 0) begin bad++; $display("FAIL restart_wait_low got=%0d exp=0", nw); end
    @(negedge clk);
    for (int a = 0; a < DEPTH; a += 3) begin
      a_read(a, d, lat, acc);
      total++; if (d !== ref_read(a)) begin bad++; $display("FAIL recleared addr=%0d got=%h exp=%h", a, d, ref_read(a)); end
    end
  endtask

  task automatic test_latency2_inflight();
    logic [DW-1:0] d, wd; int lat, nv; int vpos[$]; logic [DW-1:0] vdat[$];
    b_chipselect = 0; b_read = 0; b_write = 0; b_clken = 1; b_reset_req = 0; b_freeze = 0;
    b_address = '0; b_byteenable = '0; b_writedata = '0;
    b_reset_n = 0;
    repeat (2) @(negedge clk);
    total++; if (b_waitrequest !== 1'b1 || b_busy_clearing !== 1'b0)
      begin bad++; $display("FAIL b_reset wait=%b busy=%b exp wait=1 busy=0", b_waitrequest, b_busy_clearing); end
    b_reset_n = 1;
    #1;
    total++; if (b_waitrequest !== 1'b0) begin bad++; $display("FAIL b_first_wait got=%b exp=0", b_waitrequest); end
    @(negedge clk);
    wd = 32'hDEADBEEF;
    b_do_write(3, '0, 4'hF);
    b_do_write(3, wd, 4'b0101);
    b_do_read(3, d, lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL b_latency got=%0d exp=2", lat); end
    total++; if (d !== (wd & 32'h00FF00FF)) begin bad++; $display("FAIL b_data got=%h exp=%h", d, wd & 32'h00FF00FF); end
    @(negedge clk);
    for (int s = 0; s < 6; s++) begin
      b_chipselect = (s < 2); b_read = (s < 2);
      b_address = (s == 0) ? 5'd3 : 5'd25;
      #1;
      if (b_readdatavalid) begin vpos.push_back(s); vdat.push_back(b_readdata); end
      @(negedge clk);
    end
    b_chipselect = 0; b_read = 0;
    total++; if (vpos.size() !== 2 || vpos[0] !== 2 || vpos[1] !== 3)
      begin bad++; $display("FAIL b_b2b_positions got_n=%0d exp=2 at cycles 2,3", vpos.size()); end
    total++; if (vdat.size() == 2 && (vdat[0] !== (wd & 32'h00FF00FF) || vdat[1] !== '0))
      begin bad++; $display("FAIL b_b2b_data got=%h,%h exp=%h,0", vdat[0], vdat[1], wd & 32'h00FF00FF); end
    b_address = 5'd3; b_chipselect = 1; b_read = 1;
    @(negedge clk);
    b_chipselect = 0; b_read = 0;
    b_reset_n = 0;
    #1;
    total++; if (b_readdatavalid !== 1'b0) begin bad++; $display("FAIL b_inflight_reset_valid got=%b exp=0", b_readdatavalid); end
    @(negedge clk);
    b_reset_n = 1;
    nv = 0;
    for (int c = 0; c < 5; c++) begin #1; if (b_readdatavalid) nv++; @(negedge clk); end
    total++; if (nv !== 0) begin bad++; $display("FAIL b_inflight_dropped got=%0d exp=0", nv); end
  endtask

  initial begin
    reset_n = 0; b_reset_n = 0;
    test_reset();
    test_byte_write();
    test_read_write_collision();
    test_back_to_back();
    test_freeze();
    test_reset_during_clear();
    test_latency2_inflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1);
  end
endmodule
